// File: rtl/riscv_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the multi-cycle controller and memory.
interface riscv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences memory, IR, PC, ALU and register file.
// Optional illegal-opcode trap state is built when RISCV_ILLEGAL_TRAP_EN is defined.
module riscv_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 alu_zero,
  riscv_multicycle_ctrl_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [CNT_W-1:0]     instret,
  output logic                 trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef RISCV_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_ILL
  } class_e;

  state_e           state_q, state_d;
  class_e           class_q, class_d, dec_class;
  logic [2:0]       f3_q, f3_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             mem_req, mem_we;
  logic             unused_funct7;

  assign unused_funct7 = ^funct7;

  always_comb begin
    case (opcode)
      7'b0110011: dec_class = CL_R;
      7'b0010011: dec_class = CL_I;
      7'b0000011: dec_class = CL_LOAD;
      7'b0100011: dec_class = CL_STORE;
      7'b1100011: dec_class = CL_BRANCH;
      default:    dec_class = CL_ILL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    f3_d       = f3_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Class and branch condition are captured here so later opcode changes are ignored.
        class_d = dec_class;
        f3_d    = funct3;
        if (dec_class == CL_ILL) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          CL_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          CL_I: begin
            alu_op    = 2'b10;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          CL_BRANCH: begin
            alu_op = 2'b01;
            if ((f3_q == 3'b000 && alu_zero) || (f3_q == 3'b001 && !alu_zero)) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (class_q == CL_STORE);
        if (mem.mem_ready) begin
          if (class_q == CL_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == CL_LOAD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef RISCV_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
    // Reset silences every output combinationally, so an in-flight request drops this cycle.
    if (reset) begin
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      class_q   <= CL_R;
      f3_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      f3_q    <= f3_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;
  assign instret     = reset ? '0 : instret_q;
`ifdef RISCV_ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP) && !reset;
`else
  assign trap = 1'b0;
`endif

endmodule
